arbiter_2m: RTL and testbench
=============================

Name: arbiter_2m

Overview:
- Two-master round-robin arbiter that sits directly upstream of mux_slave.
- Observes the request lines of master "first" and master "second" plus the slave-side ack_out.
- Drives the one-hot grant[1:0] that mux_slave uses to steer address, data and command.
- Holds a grant for a whole transaction, releases it on slave ack, and alternates fairly under contention.

Parameters:
- TIMEOUT_CYCLES, 16, cycles a grant may stay open without ack before forced release; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in_first  input  1  request from master first; held high until it sees its ack.
- req_in_second  input  1  request from master second; same rule.
- ack_out  input  1  transaction-complete strobe from the slave, one cycle wide.
- grant  output  2  one-hot grant: 00 none, 01 first, 10 second; 11 never driven.
- busy  output  1  high while grant != 00.
- timeout_err  output  1  one-cycle pulse on forced release; constant 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Interface rule (decided): one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: grant=00, busy=0, timeout_err=0, state=IDLE, rr_ptr=FIRST (first wins the first contention), timeout counter=0.
- Reset asserted mid-transaction forces grant=00 immediately, without waiting for clk. No ack tracking survives reset.
- FSM states: IDLE, OWN_FIRST, OWN_SECOND, RELEASE.
- IDLE:
  - Only first requests -> OWN_FIRST.
  - Only second requests -> OWN_SECOND.
  - Both request -> the master indicated by rr_ptr.
  - No request -> stay in IDLE.
  - Latency: req sampled high at edge N gives grant valid after edge N, i.e. one cycle.
- OWN_x:
  - grant holds its one-hot value; inputs sampled by the FSM are ignored except req of the owner and ack_out.
  - ack_out=1 -> RELEASE. rr_ptr is set to the other master.
  - Owner's req drops while ack_out=0 (abort) -> RELEASE. rr_ptr is updated as for ack.
  - ack_out=1 and owner req=0 in the same cycle count as one normal completion.
- RELEASE:
  - grant=00 for exactly one cycle. This bubble lets the owner drop req after seeing ack.
  - Then unconditionally -> IDLE.
- Consequences:
  - Minimum back-to-back spacing is grant, ack, 00 bubble, arbitration, new grant.
  - Under continuous contention grants alternate 01,10,01,...
- ack_out while in IDLE or RELEASE is ignored (spurious). No state change.
- busy = (state is OWN_FIRST or OWN_SECOND).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to OWN_x and increments each cycle in OWN_x.
  - When the count reaches TIMEOUT_CYCLES-1 without ack, the next state is RELEASE and rr_ptr moves to the other master.
  - timeout_err pulses high for one cycle, coincident with grant=00.
  - If ack_out arrives in the same cycle the count reaches the limit, ack wins and there is no timeout_err.
- Undefined:
  - No counter logic; a grant is held indefinitely until ack or abort.
  - timeout_err is tied to 0.

Decomposition:
- Package arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, OWN_FIRST, OWN_SECOND, RELEASE}.
  - Constants GRANT_NONE=2'b00, GRANT_FIRST=2'b01, GRANT_SECOND=2'b10.
  - typedef logic [1:0] grant_t.
- Sub-module arb_watchdog (counter, compare, expiry flag), instantiated only under ARB_TIMEOUT_EN.
- FSM and round-robin pointer stay in arbiter_2m.

Test Plan:
- Reset then lone requester:
  - Pulse rst; req_in_first=1 at cycle 3 -> grant=01 at cycle 4, busy=1.
  - ack_out=1 at cycle 6 -> grant=00 at cycle 7, grant stays 00 at cycle 8 with req_in_first dropped.
- Contention fairness:
  - Both reqs held high; ack one cycle after each grant -> grant sequence 01,00,00,10,00,00,01.
  - Never 11, and never the same master twice in a row.
- Abort:
  - Grant=10; req_in_second drops without ack -> grant=00 next cycle, timeout_err=0.
  - Next contention goes to first.
- Reset mid-transaction:
  - grant=01 and rst asserted between edges -> grant=00 before the next clk edge.
  - After release, both requesting -> first wins.
- Spurious ack: ack_out=1 while IDLE with no reqs -> grant remains 00, busy=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Grant=01, no ack -> after 4 grant cycles grant=00 and timeout_err=1 for one cycle.
  - Pending req_in_second -> grant=10 two cycles later.
  - Variant with ack on the 4th cycle -> timeout_err stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and grant encodings for the two-master arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN_FIRST, OWN_SECOND, RELEASE} arb_state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE   = 2'b00;
  localparam grant_t GRANT_FIRST  = 2'b01;
  localparam grant_t GRANT_SECOND = 2'b10;

  function automatic grant_t grant_of(arb_state_t s);
    grant_t g;
    case (s)
      OWN_FIRST:  g = GRANT_FIRST;
      OWN_SECOND: g = GRANT_SECOND;
      default:    g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles a grant has been open and flags the last allowed one.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  // Held at zero outside ownership, so every new grant starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (!i_run) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_run && (r_count == LIMIT);

endmodule

// File: rtl/arbiter_2m.sv
// Two-master round-robin arbiter feeding mux_slave; grant held per transaction.
// Optional forced release of stalled grants when ARB_TIMEOUT_EN is defined.
module arbiter_2m
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in_first,
  input  logic       req_in_second,
  input  logic       ack_out,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  // state      | meaning
  // IDLE       | no grant, arbitrate on sampled requests
  // OWN_FIRST  | first owns the slave until ack, abort or timeout
  // OWN_SECOND | second owns the slave until ack, abort or timeout
  // RELEASE    | one-cycle 00 bubble so the owner can drop req

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("arbiter_2m: TIMEOUT_CYCLES must be within 2..255");
  end

  arb_state_t r_state, w_state_nxt;
  logic       r_rr_second, w_rr_second_nxt;
  grant_t     r_grant, w_grant_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_timeout_err, w_timeout_nxt;
  logic       w_own, w_owner_req, w_expired;

  assign w_own       = (r_state == OWN_FIRST) || (r_state == OWN_SECOND);
  assign w_owner_req = (r_state == OWN_SECOND) ? req_in_second : req_in_first;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_own),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_second   <= 1'b0;
      r_grant       <= GRANT_NONE;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_second   <= w_rr_second_nxt;
      r_grant       <= w_grant_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_second_nxt = r_rr_second;
    case (r_state)
      IDLE: begin
        if (req_in_first && (!req_in_second || !r_rr_second)) begin
          w_state_nxt = OWN_FIRST;
        end else if (req_in_second) begin
          w_state_nxt = OWN_SECOND;
        end
      end
      OWN_FIRST, OWN_SECOND: begin
        if (ack_out || !w_owner_req || w_expired) begin
          w_state_nxt     = RELEASE;
          w_rr_second_nxt = (r_state == OWN_FIRST);
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  // Ack and abort both take precedence over an expiring watchdog.
  always_comb begin
    w_grant_nxt   = grant_of(w_state_nxt);
    w_busy_nxt    = (w_state_nxt == OWN_FIRST) || (w_state_nxt == OWN_SECOND);
    w_timeout_nxt = w_own && w_expired && !ack_out && w_owner_req;
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_arbiter_2m.sv
// Scoreboarded bench for arbiter_2m: directed scenarios then randomized masters/slave.
module tb_arbiter_2m;
  import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rf = 1'b0, rs = 1'b0, ack = 1'b0;
  logic [1:0] grant;
  logic       busy, terr;

  arbiter_2m #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in_first  (rf),
    .req_in_second (rs),
    .ack_out       (ack),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (terr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic       b;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the slave (0 none, 1 first, 2 second),
  // how many grant cycles have been shown, bubble pending, whose turn on a tie.
  int m_owner, m_held;
  bit m_bubble, m_fav2;

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_bubble = 0; m_fav2 = 0;
  endtask

  task automatic model_step(input logic f, input logic s, input logic a, output exp_t e);
    bit oreq, rel, tmo;
    rel = 0; tmo = 0;
    if (m_bubble) begin
      m_bubble = 0;
    end else if (m_owner == 0) begin
      if (f && s)  m_owner = m_fav2 ? 2 : 1;
      else if (f)  m_owner = 1;
      else if (s)  m_owner = 2;
      m_held = 1;
    end else begin
      oreq = (m_owner == 1) ? f : s;
      if (a || !oreq) rel = 1;
`ifdef ARB_TIMEOUT_EN
      else if (m_held == TO) begin rel = 1; tmo = 1; end
`endif
      else m_held++;
      if (rel) begin
        m_fav2   = (m_owner == 1);
        m_owner  = 0;
        m_bubble = 1;
      end
    end
    e.g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e.b = (m_owner != 0);
    e.t = tmo;
  endtask

  task automatic step(input logic f, input logic s, input logic a);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; rf = f; rs = s; ack = a;
    model_step(f, s, a, e);
    q.push_back(e);
  endtask

  task automatic reset_hold(input int n);
    @(negedge clk);
    rst = 1'b1; rf = 1'b0; rs = 1'b0; ack = 1'b0;
    #1;
    n_cmp++;
    if (grant !== GRANT_NONE || busy !== 1'b0 || terr !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset t=%0t got grant=%b busy=%b terr=%b want 00/0/0", $time, grant, busy, terr);
    end
    model_reset();
    q.push_back('0);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      q.push_back('0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({grant, busy, terr} !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got grant=%b busy=%b terr=%b want grant=%b busy=%b terr=%b",
                 $time, grant, busy, terr, e.g, e.b, e.t);
      end
    end
  end

  initial begin
    logic mf, ms, a;
    bit   drop_f, drop_s;
    model_reset();
    reset_hold(2);

    // lone requester, ack, release
    step(0, 0, 0); step(0, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 0, 1); step(0, 0, 0); step(0, 0, 0);
    // spurious ack while idle
    step(0, 0, 1); step(0, 0, 0);
    // continuous contention, ack one cycle after each grant
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 0); step(1, 1, 1); step(1, 1, 0);
    end
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // abort by the owner
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0); step(1, 1, 1); step(0, 0, 0); step(0, 0, 0);
    // reset while first owns; first must win the next tie
    step(1, 0, 0); step(1, 0, 0);
    reset_hold(2);
    step(1, 1, 0); step(1, 1, 1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // long hold (times out when the watchdog is built in), then ack on the last cycle
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // randomized masters and slave
    mf = 0; ms = 0; drop_f = 0; drop_s = 0;
    for (int i = 0; i < 2000; i++) begin
      if (drop_f) begin mf = 0; drop_f = 0; end
      else if (!mf && $urandom_range(2) == 0) mf = 1;
      else if (mf && m_owner == 1 && $urandom_range(24) == 0) mf = 0;
      if (drop_s) begin ms = 0; drop_s = 0; end
      else if (!ms && $urandom_range(2) == 0) ms = 1;
      else if (ms && m_owner == 2 && $urandom_range(24) == 0) ms = 0;
      a = 0;
      if (m_owner != 0 && $urandom_range(2) == 0) begin
        a = 1;
        if (m_owner == 1) drop_f = 1; else drop_s = 1;
      end else if (m_owner == 0 && $urandom_range(9) == 0) begin
        a = 1;
      end
      if ($urandom_range(399) == 0) reset_hold(2);
      step(mf, ms, a);
    end

    step(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
